ifu_npc: RTL and testbench

- Instruction fetch unit with a PC register and next-PC logic.
- Sits directly upstream of the control decoder: it fetches the word at PC, holds it in an instruction register (IR), and exposes Op/Funct fields to the decoder.
- It consumes the decoder's resolved NPCOp, the immediate, and the rs value to select the next PC.
- Fetch and execute are sequenced by a small state machine with a variable-latency req/ack instruction-memory handshake.

---
 rtl/ifu_npc.sv | 123 ++++++++++++
 tb/tb_ifu_npc.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ifu_npc.sv
`default_nettype none
// ============================================================================
// Module   : ifu_npc
// Purpose  : Instruction fetch unit. Holds the PC, fetches the word at PC over
//            a req/ack instruction-memory handshake into the IR, and computes
//            the next PC from the decoder's NPCOp, immediate and rs value.
// Revision : 1.0 - initial release
// ============================================================================
module ifu_npc #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             im_req,
    output logic [31:0]      im_addr,
    input  logic [31:0]      im_rdata,
    input  logic             im_ack,
    output logic [31:0]      instr,
    output logic             instr_valid,
    input  logic             ex_done,
    input  logic [1:0]       NPCOp,
    input  logic [25:0]      IMM,
    input  logic [31:0]      RA,
    output logic [31:0]      PC,
    output logic [31:0]      PCPLUS4,
    output logic             misalign,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [0:0] {
        S_FETCH = 1'b0,
        S_HOLD  = 1'b1
    } state_t;

    localparam logic [1:0] c_NPC_SEQ = 2'b00;
    localparam logic [1:0] c_NPC_BR  = 2'b01;
    localparam logic [1:0] c_NPC_J   = 2'b10;
    localparam logic [1:0] c_NPC_JR  = 2'b11;

    state_t           r_state;
    logic             r_req;
    logic [31:0]      r_pc;
    logic [31:0]      r_ir;
    logic             r_valid;
    logic             r_misalign;
    logic [CNT_W-1:0] r_retired;

    logic [31:0]      w_pcplus4;
    logic [31:0]      w_br_off;
    logic [31:0]      w_npc;
    logic             w_jr_misalign;

    assign w_pcplus4     = r_pc + 32'd4;
    assign w_br_off      = {{14{IMM[15]}}, IMM[15:0], 2'b00};
    assign w_jr_misalign = (NPCOp == c_NPC_JR) && (RA[1:0] != 2'b00);

    // Next-PC selection; the register target drops its low bits so the PC
    // stays word aligned even when RA is not.
    always_comb begin
        w_npc = w_pcplus4;
        case (NPCOp)
            c_NPC_SEQ: w_npc = w_pcplus4;
            c_NPC_BR:  w_npc = w_pcplus4 + w_br_off;
            c_NPC_J:   w_npc = {w_pcplus4[31:28], IMM, 2'b00};
            c_NPC_JR:  w_npc = {RA[31:2], 2'b00};
            default:   w_npc = w_pcplus4;
        endcase
    end

    // Fetch/hold sequencer. r_req is low in the reset cycle and rises on the
    // first edge after release, so an ack is only honoured once req is up.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_FETCH;
            r_req      <= 1'b0;
            r_pc       <= RESET_PC;
            r_ir       <= 32'h0;
            r_valid    <= 1'b0;
            r_misalign <= 1'b0;
            r_retired  <= '0;
        end else begin
            r_misalign <= 1'b0;
            case (r_state)
                S_FETCH: begin
                    if (r_req && im_ack) begin
                        r_ir    <= im_rdata;
                        r_valid <= 1'b1;
                        r_req   <= 1'b0;
                        r_state <= S_HOLD;
                    end else begin
                        r_req   <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (ex_done) begin
                        r_pc       <= w_npc;
                        r_valid    <= 1'b0;
                        r_retired  <= r_retired + CNT_W'(1);
                        r_misalign <= w_jr_misalign;
                        r_req      <= 1'b1;
                        r_state    <= S_FETCH;
                    end
                end
                default: begin
                    r_req   <= 1'b0;
                    r_state <= S_FETCH;
                end
            endcase
        end
    end

    assign im_req      = r_req;
    assign im_addr     = r_pc;
    assign instr       = r_ir;
    assign instr_valid = r_valid;
    assign PC          = r_pc;
    assign PCPLUS4     = w_pcplus4;
    assign misalign    = r_misalign;
    assign retired     = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_ifu_npc.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifu_npc
// Purpose  : Self-checking bench for ifu_npc. Expected fetch addresses are
//            queued when ex_done is driven and compared when im_req rises.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifu_npc;

    localparam logic [31:0] c_RESET_PC = 32'h0000_3000;
    localparam int          c_CNT_W    = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              im_req;
    logic [31:0]       im_addr;
    logic [31:0]       im_rdata = 32'h0;
    logic              im_ack = 1'b0;
    logic [31:0]       instr;
    logic              instr_valid;
    logic              ex_done = 1'b0;
    logic [1:0]        NPCOp = 2'b00;
    logic [25:0]       IMM = 26'h0;
    logic [31:0]       RA = 32'h0;
    logic [31:0]       PC;
    logic [31:0]       PCPLUS4;
    logic              misalign;
    logic [c_CNT_W-1:0] retired;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] q_exp_pc[$];
    logic [31:0] m_ret;

    typedef struct {
        logic [1:0]  op;
        logic [25:0] imm;
        logic [31:0] ra;
        logic [31:0] exp_pc;
        logic        exp_mis;
    } vec_t;
    vec_t vecs[11];

    ifu_npc #(.RESET_PC(c_RESET_PC), .CNT_W(c_CNT_W)) dut (
        .clk(clk), .rst(rst),
        .im_req(im_req), .im_addr(im_addr), .im_rdata(im_rdata), .im_ack(im_ack),
        .instr(instr), .instr_valid(instr_valid),
        .ex_done(ex_done), .NPCOp(NPCOp), .IMM(IMM), .RA(RA),
        .PC(PC), .PCPLUS4(PCPLUS4), .misalign(misalign), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Wait for a request, compare its address with the scoreboard, stall the
    // ack for n_wait cycles, then return the word.
    task automatic do_fetch(input int n_wait, input logic [31:0] word);
        int cnt = 0;
        logic [31:0] exp_addr;
        while (!im_req && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check("fetch_req_seen", {31'b0, im_req}, 32'd1);
        if (!im_req) return;
        if (q_exp_pc.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0 + q_exp_pc.size());
            exp_addr = 32'hxxxx_xxxx;
        end else begin
            exp_addr = q_exp_pc.pop_front();
        end
        check("im_addr", im_addr, exp_addr);
        for (int w = 0; w < n_wait; w++) begin
            im_ack = 1'b0;
            @(negedge clk);
            check("req_held", {31'b0, im_req}, 32'd1);
            check("addr_held", im_addr, exp_addr);
        end
        im_ack   = 1'b1;
        im_rdata = word;
        @(negedge clk);
        im_ack   = 1'b0;
        check("instr_valid_set", {31'b0, instr_valid}, 32'd1);
        check("instr", instr, word);
        check("req_dropped", {31'b0, im_req}, 32'd0);
    endtask

    task automatic do_exec(input logic [1:0] op, input logic [25:0] imm,
                           input logic [31:0] ra, input logic [31:0] exp_pc,
                           input logic exp_mis);
        NPCOp   = op;
        IMM     = imm;
        RA      = ra;
        ex_done = 1'b1;
        q_exp_pc.push_back(exp_pc);
        m_ret = m_ret + 32'd1;
        @(negedge clk);
        ex_done = 1'b0;
        check("pc", PC, exp_pc);
        check("pcplus4", PCPLUS4, exp_pc + 32'd4);
        check("misalign", {31'b0, misalign}, {31'b0, exp_mis});
        check("retired", retired, m_ret);
        check("instr_valid_clr", {31'b0, instr_valid}, 32'd0);
        check("req_back_to_back", {31'b0, im_req}, 32'd1);
    endtask

    initial begin
        vecs[0]  = '{2'b00, 26'h0,        32'h0,         32'h0000_3010, 1'b0};
        vecs[1]  = '{2'b01, 26'h000_FFFC, 32'h0,         32'h0000_3004, 1'b0};
        vecs[2]  = '{2'b01, 26'h000_0003, 32'h0,         32'h0000_3014, 1'b0};
        vecs[3]  = '{2'b01, 26'h000_FFFC, 32'h0,         32'h0000_3008, 1'b0};
        vecs[4]  = '{2'b10, 26'h000_0C10, 32'h0,         32'h0000_3040, 1'b0};
        vecs[5]  = '{2'b11, 26'h0,        32'h0000_3022, 32'h0000_3020, 1'b1};
        vecs[6]  = '{2'b00, 26'h0,        32'h0,         32'h0000_3024, 1'b0};
        vecs[7]  = '{2'b11, 26'h0,        32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0};
        vecs[8]  = '{2'b00, 26'h0,        32'h0,         32'h0000_0000, 1'b0};
        vecs[9]  = '{2'b10, 26'h3FF_FFFF, 32'h0,         32'h0FFF_FFFC, 1'b0};
        vecs[10] = '{2'b01, 26'h3FF_0001, 32'h0,         32'h1000_0004, 1'b0};

        m_ret = 32'd0;
        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_pc", PC, c_RESET_PC);
        check("rst_instr", instr, 32'h0);
        check("rst_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_req", {31'b0, im_req}, 32'd0);
        check("rst_misalign", {31'b0, misalign}, 32'd0);
        check("rst_retired", retired, 32'd0);
        rst = 1'b0;
        q_exp_pc.push_back(c_RESET_PC);

        // Sequential execution with zero-wait memory
        do_fetch(0, 32'h2008_0005); do_exec(2'b00, 26'h0, 32'h0, 32'h0000_3004, 1'b0);
        do_fetch(0, 32'h2008_0005); do_exec(2'b00, 26'h0, 32'h0, 32'h0000_3008, 1'b0);
        do_fetch(0, 32'h2008_0005); do_exec(2'b00, 26'h0, 32'h0, 32'h0000_300C, 1'b0);
        check("retired_3", retired, 32'd3);

        // Table-driven next-PC cases
        for (int i = 0; i < 11; i++) begin
            do_fetch(i % 3, 32'h1000_0000 + i);
            do_exec(vecs[i].op, vecs[i].imm, vecs[i].ra, vecs[i].exp_pc, vecs[i].exp_mis);
        end

        // Wait states with ex_done pulsed during FETCH
        ex_done = 1'b1; NPCOp = 2'b11; RA = 32'h0000_0100;
        @(negedge clk);
        ex_done = 1'b0;
        check("fetch_exdone_pc", PC, 32'h1000_0004);
        check("fetch_exdone_ret", retired, m_ret);
        do_fetch(3, 32'hDEAD_BEEC);
        check("hold_pc", PC, 32'h1000_0004);

        // Retired counter wrap
        force dut.r_retired = '1;
        @(negedge clk);
        release dut.r_retired;
        m_ret = 32'hFFFF_FFFF;
        do_exec(2'b00, 26'h0, 32'h0, 32'h1000_0008, 1'b0);
        check("retired_wrap", retired, 32'd0);

        // Reset during FETCH coincident with ack
        rst = 1'b1; im_ack = 1'b1; im_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        rst = 1'b0; im_ack = 1'b0;
        check("rstf_instr", instr, 32'h0);
        check("rstf_valid", {31'b0, instr_valid}, 32'd0);
        check("rstf_pc", PC, c_RESET_PC);
        check("rstf_req", {31'b0, im_req}, 32'd0);
        q_exp_pc.delete();
        q_exp_pc.push_back(c_RESET_PC);
        m_ret = 32'd0;

        // Reset during HOLD coincident with ex_done
        do_fetch(1, 32'h1234_5678);
        rst = 1'b1; ex_done = 1'b1; NPCOp = 2'b00;
        @(negedge clk);
        rst = 1'b0; ex_done = 1'b0;
        check("rsth_retired", retired, 32'd0);
        check("rsth_pc", PC, c_RESET_PC);
        check("rsth_valid", {31'b0, instr_valid}, 32'd0);
        q_exp_pc.delete();
        q_exp_pc.push_back(c_RESET_PC);

        do_fetch(0, 32'h2008_0005);
        do_exec(2'b00, 26'h0, 32'h0, 32'h0000_3004, 1'b0);
        check("final_retired", retired, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Absolute time limit so the bench always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, checks %0d", n_checks);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
